sram_burst_controller: RTL and testbench
========================================

# sram_burst_controller

Parametrised SRAM controller for the 16-bit off-chip SRAM, serving cache-line fills and byte-masked word writes. It generalises the fixed 64-bit stall-counter controller with configurable word width, burst length and wait states, a registered one-cycle `ready` pulse, and byte enables. It sits between the data cache (miss/write-back path) and the SRAM pins, and drives every pin from registers only.

## Interface
- `DATA_W`, 32: CPU word width; multiple of 16.
- `BURST`, 2: words returned per read (line fill); power of 2, ≥1.
- `WAIT_CYCLES`, 5: clock cycles per SRAM beat; ≥2.
- `SRAM_AW`, 18: SRAM half-word address width.
- Derived: `BPW = DATA_W/16` (beats per word); `BEATS = BURST*BPW`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `read_en` in 1: line-read request; level, held until `ready`.
- `write_en` in 1: word-write request; level, held until `ready`.
- `address` in 32: byte address.
- `write_data` in DATA_W: write word.
- `wr_be` in DATA_W/8: byte enables for the write; bit i maps to byte i.
- `read_data` out BURST*DATA_W: line data; valid from the `ready` cycle until the next read completes.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high whenever state ≠ IDLE.
- `SRAM_DQ` inout 16: data bus; driven only in WRITE.
- `SRAM_ADDR` out SRAM_AW: half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: active-low strobes.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Counters:
  - `cyc`: 0..WAIT_CYCLES-1 within a beat.
  - `beat`: 0..N-1, where N = BEATS for READ and BPW for WRITE.
- IDLE:
  - `read_en`=1 → READ; else `write_en`=1 → WRITE; else stay in IDLE.
  - Read has priority when both are high.
  - On leaving IDLE, latch `address`, `write_data` and `wr_be`. `cyc` and `beat` are 0.
- Base address:
  - READ: `address[SRAM_AW:1]` with its low log2(BEATS) bits zeroed (line-aligned).
  - WRITE: `address[SRAM_AW:1]` with its low log2(BPW) bits zeroed.
  - `SRAM_ADDR` = base + `beat`.
- READ:
  - OE_N=0, CE_N=0, UB_N=LB_N=0, WE_N=1; DQ high-Z.
  - At `cyc`=WAIT_CYCLES-1, capture DQ into `read_data[beat*16 +: 16]`.
  - After the last beat → DONE.
- WRITE:
  - CE_N=0, OE_N=1; DQ = `write_data[beat*16 +: 16]` (latched copy).
  - LB_N = ~`wr_be[2*beat]`, UB_N = ~`wr_be[2*beat+1]`.
  - WE_N=0 for `cyc` 0..WAIT_CYCLES-2 and WE_N=1 at `cyc`=WAIT_CYCLES-1. This gives one cycle of address/data hold.
  - After the last beat → DONE.
  - `wr_be`=0 still runs the full sequence with UB_N=LB_N=1.
- DONE: `ready`=1 for one cycle, all strobes inactive, → IDLE unconditionally.
- Requester must drop its enable in the cycle after `ready`. An enable still high in IDLE starts a new transaction.
- Data ordering is little-endian: beat k holds bits [16k+15:16k].

## Timing
- Reset values (the cycle after the edge with `rst`=0):
  - state IDLE, `ready`=0, `busy`=0, `read_data`=0, `SRAM_ADDR`=0.
  - WE_N=OE_N=CE_N=UB_N=LB_N=1; DQ high-Z.
- Reset mid-operation: abort at that edge. No `ready` pulse; partial `read_data` is cleared to 0; WE_N returns to 1 and DQ is released in the next cycle.
- Request sampled at edge E0 (state IDLE):
  - The SRAM access occupies the next N*WAIT_CYCLES cycles.
  - `ready` is high in cycle N*WAIT_CYCLES+1 after E0.
  - Defaults: read = 20 access cycles with `ready` in cycle 21; write = 10 access cycles with `ready` in cycle 11.
- Minimum spacing between `ready` pulses of back-to-back requests: N*WAIT_CYCLES+2 cycles (includes the IDLE sampling cycle).
- No combinational path from any input to any SRAM pin or to `ready`.
- Enable changes are ignored outside IDLE.

## Test plan
- Reset with `rst`=0 for 3 cycles → all outputs at their reset values; DQ=Z; `ready` stays 0 with both enables low.
- Read at `address`=0x0000_000C, SRAM model preloaded with half-words 0x1111, 0x2222, 0x3333, 0x4444 at addresses 4..7 → `SRAM_ADDR` steps 4,5,6,7 every 5 cycles; `ready` in cycle 21; `read_data`=0x4444_3333_2222_1111.
- Write 0xDEAD_BEEF to `address` 0x10 with `wr_be`=4'b0111 → addresses 8 then 9; beat 0 drives 0xBEEF with UB_N=LB_N=0; beat 1 drives 0xDEAD with UB_N=1, LB_N=0; WE_N low 4 cycles per beat; `ready` in cycle 11; model holds 0xBEEF and 0x??AD (byte 3 unchanged).
- `read_en`=`write_en`=1 together → read performed, no WE_N activity; `write_en` still high after `ready` → write starts from the following IDLE.
- Pull `rst` low during beat 2 of a read → next cycle IDLE, `read_data`=0, no `ready`; a new read afterwards completes normally in 21 cycles.
- Parameter sweep DATA_W=64, BURST=1, WAIT_CYCLES=2 → read = 4 beats, `ready` in cycle 9, data correct.

Source files
------------

// File: rtl/sram_burst_controller.sv
// Burst controller for a 16-bit asynchronous SRAM: line reads and byte-masked word writes,
// each beat stretched over WAIT_CYCLES clocks, with every SRAM pin driven straight from a flop.
module sram_burst_controller #(
    parameter int DATA_W      = 32,
    parameter int BURST       = 2,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_en,
    input  logic                      write_en,
    input  logic [31:0]               address,
    input  logic [DATA_W-1:0]         write_data,
    input  logic [DATA_W/8-1:0]       wr_be,
    output logic [BURST*DATA_W-1:0]   read_data,
    output logic                      ready,
    output logic                      busy,
    inout  wire  [15:0]               SRAM_DQ,
    output logic [SRAM_AW-1:0]        SRAM_ADDR,
    output logic                      SRAM_WE_N,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_UB_N,
    output logic                      SRAM_LB_N
);

    localparam int BPW     = DATA_W / 16;
    localparam int BEATS   = BURST * BPW;
    localparam int LINE_LG = $clog2(BEATS);
    localparam int WORD_LG = $clog2(BPW);
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CYC_W   = $clog2(WAIT_CYCLES);

    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(WAIT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] READ_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] WRITE_LAST = BEAT_W'(BPW - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state, state_n;
    logic [CYC_W-1:0]       cyc, cyc_n;
    logic [BEAT_W-1:0]      beat, beat_n;
    logic [SRAM_AW-1:0]     hw_addr, hw_addr_n, base_n;
    logic [DATA_W-1:0]      wdata, wdata_n;
    logic [DATA_W/8-1:0]    be, be_n;
    logic [15:0]            dq_out;
    logic                   dq_oe;
    int                     wb;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[0]};
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    // Clear the low lg bits of a half-word address (line or word alignment).
    function automatic logic [SRAM_AW-1:0] align(input logic [SRAM_AW-1:0] hw, input int lg);
        return hw & ~((SRAM_AW'(1) << lg) - SRAM_AW'(1));
    endfunction

    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        beat_n    = beat;
        hw_addr_n = hw_addr;
        wdata_n   = wdata;
        be_n      = be;
        case (state)
            IDLE: begin
                cyc_n  = '0;
                beat_n = '0;
                if (read_en || write_en) begin
                    state_n   = read_en ? READ : WRITE;
                    hw_addr_n = address[SRAM_AW:1];
                    wdata_n   = write_data;
                    be_n      = wr_be;
                end
            end
            READ, WRITE: begin
                if (cyc == CYC_LAST) begin
                    cyc_n = '0;
                    if (beat == ((state == READ) ? READ_LAST : WRITE_LAST)) begin
                        state_n = DONE;
                        beat_n  = '0;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            DONE: state_n = IDLE;
        endcase
        base_n = align(hw_addr_n, (state_n == READ) ? LINE_LG : WORD_LG);
        wb     = int'(beat_n) % BPW;
    end

    // Pins are registered from next-state values so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cyc       <= '0;
            beat      <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            beat  <= beat_n;
            ready <= (state_n == DONE);
            busy  <= (state_n != IDLE);
            if (state == READ && cyc == CYC_LAST)
                read_data[int'(beat)*16 +: 16] <= SRAM_DQ;
            SRAM_CE_N <= !(state_n == READ || state_n == WRITE);
            SRAM_OE_N <= (state_n != READ);
            // WE_N rises one cycle before the beat ends to hold address and data.
            SRAM_WE_N <= !(state_n == WRITE && cyc_n != CYC_LAST);
            dq_oe     <= (state_n == WRITE);
            case (state_n)
                READ: begin
                    SRAM_UB_N <= 1'b0;
                    SRAM_LB_N <= 1'b0;
                end
                WRITE: begin
                    SRAM_UB_N <= ~be_n[2*wb+1];
                    SRAM_LB_N <= ~be_n[2*wb];
                end
                default: begin
                    SRAM_UB_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                end
            endcase
            if (state_n == READ || state_n == WRITE)
                SRAM_ADDR <= base_n + SRAM_AW'(beat_n);
        end
    end

    always_ff @(posedge clk) begin
        hw_addr <= hw_addr_n;
        wdata   <= wdata_n;
        be      <= be_n;
        dq_out  <= wdata_n[16*wb +: 16];
    end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Bench for sram_burst_controller: default instance plus a DATA_W=64/BURST=1/WAIT_CYCLES=2 instance,
// each attached to a small behavioural SRAM, compared against an array-based reference.
module tb_sram_burst_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_err    = 0;
    int n_checks = 0;

    // Instance 1: defaults
    logic        rd1 = 0, wr1 = 0;
    logic [31:0] addr1 = 0, wdata1 = 0;
    logic [3:0]  be1 = 0;
    logic [63:0] rdata1;
    logic        rdy1, busy1, we1, oe1, ce1, ub1, lb1;
    logic [17:0] sa1;
    wire  [15:0] dq1;

    // Instance 2: parameter sweep
    logic        rd2 = 0;
    logic        wr2 = 0;
    logic [31:0] addr2 = 0;
    logic [63:0] wdata2 = 0;
    logic [7:0]  be2 = 0;
    logic [63:0] rdata2;
    logic        rdy2, busy2, we2, oe2, ce2, ub2, lb2;
    logic [17:0] sa2;
    wire  [15:0] dq2;

    sram_burst_controller dut1 (
        .clk(clk), .rst(rst), .read_en(rd1), .write_en(wr1), .address(addr1),
        .write_data(wdata1), .wr_be(be1), .read_data(rdata1), .ready(rdy1), .busy(busy1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
        .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    sram_burst_controller #(.DATA_W(64), .BURST(1), .WAIT_CYCLES(2), .SRAM_AW(18)) dut2 (
        .clk(clk), .rst(rst), .read_en(rd2), .write_en(wr2), .address(addr2),
        .write_data(wdata2), .wr_be(be2), .read_data(rdata2), .ready(rdy2), .busy(busy2),
        .SRAM_DQ(dq2), .SRAM_ADDR(sa2), .SRAM_WE_N(we2), .SRAM_OE_N(oe2),
        .SRAM_CE_N(ce2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2)
    );

    // Behavioural SRAMs (256 half-words each) and their reference images
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];
    logic [15:0] ref1 [256];
    logic [15:0] ref2 [256];
    logic        mem_ok = 1'b0;

    function automatic logic [15:0] init_val(input int i);
        if (i >= 4 && i <= 7) return 16'(32'h1111 * (i - 3));
        return 16'((i * 40503) ^ 32'h5A5A);
    endfunction

    assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[7:0]] : 16'hzzzz;
    assign dq2 = (!ce2 && !oe2 && we2) ? mem2[sa2[7:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_val(i);
                mem2[i] <= init_val(i) ^ 16'hFFFF;
            end
            mem_ok <= 1'b1;
        end else if (!ce1 && !we1) begin
            if (!lb1) mem1[sa1[7:0]][7:0]  <= dq1[7:0];
            if (!ub1) mem1[sa1[7:0]][15:8] <= dq1[15:8];
        end
    end

    // Selected-instance view for the shared read task
    logic        sel = 1'b0;
    logic        m_ready, m_busy, m_we, m_oe, m_ce, m_ub, m_lb;
    logic [17:0] m_addr;
    logic [63:0] m_rdata;
    always_comb begin
        m_ready = sel ? rdy2   : rdy1;
        m_busy  = sel ? busy2  : busy1;
        m_we    = sel ? we2    : we1;
        m_oe    = sel ? oe2    : oe1;
        m_ce    = sel ? ce2    : ce1;
        m_ub    = sel ? ub2    : ub1;
        m_lb    = sel ? lb2    : lb1;
        m_addr  = sel ? sa2    : sa1;
        m_rdata = sel ? rdata2 : rdata1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Line read on instance d; with also_wr, write_en is raised alongside and left high afterwards.
    task automatic do_read(input int d, input logic [31:0] a, input logic also_wr,
                           input logic [31:0] wd, input logic [3:0] be);
        int          w, base;
        logic [63:0] exp;
        logic        bad, got_rdy;
        w    = d ? 2 : 5;
        base = (int'(a) >> 1) & ~3;
        for (int k = 0; k < 4; k++)
            exp[16*k +: 16] = d ? ref2[base+k] : ref1[base+k];
        @(negedge clk);
        check_eq("idle_ready_low", {63'd0, m_ready}, 64'd0);
        sel = (d != 0);
        if (d != 0) begin
            rd2 = 1; addr2 = a;
        end else begin
            rd1 = 1; addr1 = a;
            if (also_wr) begin
                wr1 = 1; wdata1 = wd; be1 = be;
            end
        end
        @(posedge clk);
        bad = 0;
        got_rdy = 0;
        for (int c = 1; c <= 4*w + 6 && !got_rdy; c++) begin
            @(negedge clk);
            if (c == 1) check_eq("rd_busy", {63'd0, m_busy}, 64'd1);
            if (c <= 4*w) begin
                if (m_we !== 1'b1 || m_oe !== 1'b0 || m_ce !== 1'b0 || m_ub !== 1'b0 || m_lb !== 1'b0)
                    bad = 1;
                if ((c - 1) % w == 0)
                    check_eq("rd_addr", 64'(m_addr), 64'(base + (c - 1) / w));
            end
            if (m_ready) begin
                got_rdy = 1;
                check_eq("rd_ready_cycle", 64'(c), 64'(4*w + 1));
                rd1 = 0;
                rd2 = 0;
            end
        end
        rd1 = 0;
        rd2 = 0;
        check_eq("rd_ready_seen", {63'd0, got_rdy}, 64'd1);
        check_eq("rd_strobes", {63'd0, bad}, 64'd0);
        check_eq("rd_data", m_rdata, exp);
    endtask

    // Word write on instance 1, checking pins per beat and the resulting SRAM contents.
    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int   base, b, cy;
        logic bad [2];
        logic got_rdy;
        base = (int'(a) >> 1) & ~1;
        @(negedge clk);
        check_eq("idle_ready_low", {63'd0, rdy1}, 64'd0);
        sel = 1'b0;
        wr1 = 1; rd1 = 0; addr1 = a; wdata1 = wd; be1 = be;
        @(posedge clk);
        bad[0] = 0;
        bad[1] = 0;
        got_rdy = 0;
        for (int c = 1; c <= 16 && !got_rdy; c++) begin
            @(negedge clk);
            if (c <= 10) begin
                b  = (c - 1) / 5;
                cy = (c - 1) % 5;
                if (ce1 !== 1'b0 || oe1 !== 1'b1 || we1 !== (cy == 4) ||
                    sa1 !== 18'(base + b) || lb1 !== !be[2*b] || ub1 !== !be[2*b+1])
                    bad[b] = 1;
                if (!we1 && dq1 !== wd[16*b +: 16]) bad[b] = 1;
            end
            if (rdy1) begin
                got_rdy = 1;
                check_eq("wr_ready_cycle", 64'(c), 64'd11);
                wr1 = 0;
            end
        end
        wr1 = 0;
        check_eq("wr_ready_seen", {63'd0, got_rdy}, 64'd1);
        check_eq("wr_beat0_pins", {63'd0, bad[0]}, 64'd0);
        check_eq("wr_beat1_pins", {63'd0, bad[1]}, 64'd0);
        for (int i = 0; i < 4; i++)
            if (be[i]) ref1[base + i/2][8*(i%2) +: 8] = wd[8*i +: 8];
        check_eq("wr_mem_lo", 64'(mem1[base]), 64'(ref1[base]));
        check_eq("wr_mem_hi", 64'(mem1[base+1]), 64'(ref1[base+1]));
    endtask

    initial begin
        logic [15:0] old9;
        for (int i = 0; i < 256; i++) begin
            ref1[i] = init_val(i);
            ref2[i] = init_val(i) ^ 16'hFFFF;
        end

        // Reset for three cycles
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {63'd0, rdy1}, 64'd0);
        check_eq("rst_busy", {63'd0, busy1}, 64'd0);
        check_eq("rst_rdata", rdata1, 64'd0);
        check_eq("rst_addr", 64'(sa1), 64'd0);
        check_eq("rst_strobes", {59'd0, we1, oe1, ce1, ub1, lb1}, 64'h1F);
        check_eq("rst_strobes2", {59'd0, we2, oe2, ce2, ub2, lb2}, 64'h1F);
        check_eq("rst_rdata2", rdata2, 64'd0);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("idle_quiet", {62'd0, rdy1, busy1}, 64'd0);
        end

        // Directed line read and byte-masked write
        do_read(0, 32'h0000_000C, 0, 0, 0);
        check_eq("dir_rd_line", rdata1, 64'h4444_3333_2222_1111);
        old9 = ref1[9];
        do_write(32'h10, 32'hDEAD_BEEF, 4'b0111);
        check_eq("dir_wr_8", 64'(mem1[8]), 64'h0000_BEEF);
        check_eq("dir_wr_9", 64'(mem1[9]), 64'({old9[15:8], 8'hAD}));

        // Both enables together: read wins, then the held write starts from the next IDLE
        do_read(0, 32'h0000_0040, 1, 32'h1234_5678, 4'b1111);
        do_write(32'h0000_0040, 32'h1234_5678, 4'b1111);

        // Reset during beat 2 of a read
        @(negedge clk);
        rd1 = 1; addr1 = 32'h20;
        @(posedge clk);
        repeat (12) @(negedge clk);
        rst = 0; rd1 = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_state", {60'd0, busy1, rdy1, we1, oe1}, 64'h3);
        check_eq("abort_rdata", rdata1, 64'd0);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_ready", {63'd0, rdy1}, 64'd0);
        end
        do_read(0, 32'h20, 0, 0, 0);

        // Randomised traffic on the default instance
        for (int t = 0; t < 24; t++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 0) do_read(0, ra, 0, 0, 0);
            else do_write(ra, $urandom, 4'($urandom_range(0, 15)));
        end

        // Parameter-sweep instance: directed then random reads
        do_read(1, 32'h0000_000C, 0, 0, 0);
        for (int t = 0; t < 6; t++)
            do_read(1, 32'($urandom_range(0, 511)), 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

endmodule
